// File: rtl/sq_period_avg.sv
// sq_period_avg: period-synchronous boxcar averager for the square-reference lock-in chain
// Ports: clk (rising edge), rst (async active-low), en (low aborts/clears accumulation),
//        ref_in (square reference), in (signed R-bit demodulated sample), log_n (window of
//        2^log_n ref periods), shift (output scaling), out (sat_R(sum >>> shift)), sum (A-bit
//        window sum), nsamp (samples in window), ovf (accumulator saturated), valid (1-cycle strobe)
module sq_period_avg #(
    parameter int R = 14,
    parameter int A = 40
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                en,
    input  logic                ref_in,
    input  logic signed [R-1:0] in,
    input  logic [3:0]          log_n,
    input  logic [5:0]          shift,
    output logic signed [R-1:0] out,
    output logic signed [A-1:0] sum,
    output logic [31:0]         nsamp,
    output logic                ovf,
    output logic                valid
);
    typedef enum logic {IDLE, ACCUM} state_t;

    localparam logic signed [A-1:0] A_MAX = {1'b0, {(A-1){1'b1}}};
    localparam logic signed [A-1:0] A_MIN = {1'b1, {(A-1){1'b0}}};
    localparam logic signed [R-1:0] R_MAX = {1'b0, {(R-1){1'b1}}};
    localparam logic signed [R-1:0] R_MIN = {1'b1, {(R-1){1'b0}}};

    state_t              state_q, state_d;
    logic                ref_q;
    logic signed [A-1:0] acc_q, acc_d, sum_q, sum_d;
    logic [31:0]         cnt_q, cnt_d, nsamp_q, nsamp_d;
    logic [15:0]         per_q, per_d;
    logic [3:0]          n_lat_q, n_lat_d;
    logic                ovf_w_q, ovf_w_d, ovf_q, ovf_d, valid_q, valid_d;
    logic signed [R-1:0] out_q, out_d;

    logic                edge_det, closing, acc_sat, fits;
    logic signed [A:0]   acc_ext;
    logic signed [A-1:0] acc_add, acc_shr, in_ext;
    logic [31:0]         cnt_inc;
    logic [16:0]         per_inc;

    always_comb begin
        edge_det = ref_in & ~ref_q;
        in_ext   = {{(A-R){in[R-1]}}, in};
        // One extra bit catches overflow: top two bits disagree when the A-bit sum wrapped
        acc_ext  = {acc_q[A-1], acc_q} + {in_ext[A-1], in_ext};
        acc_sat  = acc_ext[A] ^ acc_ext[A-1];
        acc_add  = acc_sat ? (acc_ext[A] ? A_MIN : A_MAX) : acc_ext[A-1:0];
        cnt_inc  = &cnt_q ? cnt_q : cnt_q + 32'd1;
        per_inc  = {1'b0, per_q} + 17'd1;
        closing  = (state_q == ACCUM) && edge_det && (per_inc == (17'd1 << n_lat_q));
        acc_shr  = acc_q >>> shift;
        // Result fits in R bits when every bit above the R-bit sign equals it
        fits     = acc_shr[A-1:R-1] == {(A-R+1){acc_shr[R-1]}};
        state_d  = state_q;
        acc_d    = acc_q;
        cnt_d    = cnt_q;
        per_d    = per_q;
        n_lat_d  = n_lat_q;
        ovf_w_d  = ovf_w_q;
        sum_d    = sum_q;
        nsamp_d  = nsamp_q;
        ovf_d    = ovf_q;
        out_d    = out_q;
        valid_d  = 1'b0;
        if (!en) begin
            state_d = IDLE;
            acc_d   = '0;
            cnt_d   = '0;
            per_d   = '0;
            ovf_w_d = 1'b0;
        end else if (state_q == IDLE || closing) begin
            if (closing) begin
                sum_d   = acc_q;
                nsamp_d = cnt_q;
                ovf_d   = ovf_w_q;
                out_d   = fits ? acc_shr[R-1:0] : (acc_shr[A-1] ? R_MIN : R_MAX);
                valid_d = 1'b1;
            end
            // The edge sample opens the next window, never the one just closed
            state_d = edge_det ? ACCUM : IDLE;
            acc_d   = edge_det ? in_ext : '0;
            cnt_d   = edge_det ? 32'd1 : 32'd0;
            per_d   = '0;
            ovf_w_d = 1'b0;
            n_lat_d = edge_det ? log_n : n_lat_q;
        end else begin
            acc_d   = acc_add;
            cnt_d   = cnt_inc;
            ovf_w_d = ovf_w_q | acc_sat;
            per_d   = edge_det ? per_inc[15:0] : per_q;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            ref_q   <= 1'b0;
            acc_q   <= '0;
            cnt_q   <= '0;
            per_q   <= '0;
            n_lat_q <= '0;
            ovf_w_q <= 1'b0;
            sum_q   <= '0;
            nsamp_q <= '0;
            ovf_q   <= 1'b0;
            out_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ref_q   <= ref_in;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            per_q   <= per_d;
            n_lat_q <= n_lat_d;
            ovf_w_q <= ovf_w_d;
            sum_q   <= sum_d;
            nsamp_q <= nsamp_d;
            ovf_q   <= ovf_d;
            out_q   <= out_d;
            valid_q <= valid_d;
        end
    end

    assign out   = out_q;
    assign sum   = sum_q;
    assign nsamp = nsamp_q;
    assign ovf   = ovf_q;
    assign valid = valid_q;
endmodule

// File: tb/tb_sq_period_avg.sv
// tb_sq_period_avg: directed self-checking bench for sq_period_avg (R=14, A=20)
module tb_sq_period_avg;
    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               en = 1'b0;
    logic               ref_in = 1'b0;
    logic signed [13:0] in = '0;
    logic [3:0]         log_n = '0;
    logic [5:0]         shift = '0;
    logic signed [13:0] out;
    logic signed [19:0] sum;
    logic [31:0]        nsamp;
    logic               ovf;
    logic               valid;

    int passed = 0;
    int total = 0;
    int ph = 0;
    int cyc = 0;
    int vcount = 0;
    int vfirst = -1;
    logic consec = 1'b0;
    logic prev_v = 1'b0;
    logic signed [13:0] in_hi = '0;
    logic signed [13:0] in_lo = '0;

    sq_period_avg #(.R(14), .A(20)) dut (
        .clk(clk), .rst(rst), .en(en), .ref_in(ref_in), .in(in), .log_n(log_n),
        .shift(shift), .out(out), .sum(sum), .nsamp(nsamp), .ovf(ovf), .valid(valid)
    );

    always #5 clk = ~clk;

    // Drives n cycles of a 10-cycle (5 high / 5 low) reference, or ref held low when hold=1
    task automatic run(input int n, input bit hold);
        vcount = 0;
        vfirst = -1;
        consec = 1'b0;
        for (int i = 0; i < n; i++) begin
            ref_in = hold ? 1'b0 : ((ph % 10) < 5);
            in = ref_in ? in_hi : in_lo;
            if (!hold) ph++;
            @(posedge clk);
            #1;
            if (valid) begin
                if (vcount == 0) vfirst = cyc;
                vcount++;
                if (prev_v) consec = 1'b1;
            end
            prev_v = valid;
            cyc++;
        end
    endtask

    task automatic do_reset();
        en = 1'b0;
        ref_in = 1'b0;
        in = '0;
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ph = 0;
        cyc = 0;
        prev_v = 1'b0;
    endtask

    task automatic test_reset();
        @(posedge clk);
        #1;
        total++; if (out !== 14'sd0) $display("FAIL reset_out got %0d want 0", out); else passed++;
        total++; if (sum !== 20'sd0) $display("FAIL reset_sum got %0d want 0", sum); else passed++;
        total++; if (nsamp !== 32'd0) $display("FAIL reset_nsamp got %0d want 0", nsamp); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL reset_ovf got %b want 0", ovf); else passed++;
        total++; if (valid !== 1'b0) $display("FAIL reset_valid got %b want 0", valid); else passed++;
    endtask

    task automatic test_basic();
        do_reset();
        en = 1'b1; log_n = 4'd0; shift = 6'd0; in_hi = 14'sd100; in_lo = 14'sd100;
        run(31, 1'b0);
        total++; if (vcount !== 3) $display("FAIL basic_count got %0d want 3", vcount); else passed++;
        total++; if (vfirst !== 10) $display("FAIL basic_first got %0d want 10", vfirst); else passed++;
        total++; if (consec !== 1'b0) $display("FAIL basic_consec got %b want 0", consec); else passed++;
        total++; if (sum !== 20'sd1000) $display("FAIL basic_sum got %0d want 1000", sum); else passed++;
        total++; if (nsamp !== 32'd10) $display("FAIL basic_nsamp got %0d want 10", nsamp); else passed++;
        total++; if (out !== 14'sd1000) $display("FAIL basic_out got %0d want 1000", out); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL basic_ovf got %b want 0", ovf); else passed++;
    endtask

    task automatic test_multi_period();
        do_reset();
        en = 1'b1; log_n = 4'd2; shift = 6'd3; in_hi = 14'sd100; in_lo = 14'sd100;
        run(41, 1'b0);
        total++; if (vfirst !== 40 || vcount !== 1) $display("FAIL multi_first got %0d/%0d want 40/1", vfirst, vcount); else passed++;
        total++; if (sum !== 20'sd4000) $display("FAIL multi_sum got %0d want 4000", sum); else passed++;
        total++; if (nsamp !== 32'd40) $display("FAIL multi_nsamp got %0d want 40", nsamp); else passed++;
        total++; if (out !== 14'sd500) $display("FAIL multi_out got %0d want 500", out); else passed++;
        run(4, 1'b0);
        log_n = 4'd0;
        run(36, 1'b0);
        total++; if (vfirst !== 80 || vcount !== 1) $display("FAIL multi_second got %0d/%0d want 80/1", vfirst, vcount); else passed++;
        total++; if (nsamp !== 32'd40) $display("FAIL multi_held_n got %0d want 40", nsamp); else passed++;
        run(10, 1'b0);
        total++; if (vfirst !== 90 || vcount !== 1) $display("FAIL multi_third got %0d/%0d want 90/1", vfirst, vcount); else passed++;
        total++; if (nsamp !== 32'd10) $display("FAIL multi_new_n got %0d want 10", nsamp); else passed++;
        total++; if (out !== 14'sd125) $display("FAIL multi_new_out got %0d want 125", out); else passed++;
    endtask

    task automatic test_negative_floor();
        do_reset();
        en = 1'b1; log_n = 4'd0; shift = 6'd2; in_hi = -14'sd3; in_lo = -14'sd3;
        run(11, 1'b0);
        total++; if (vfirst !== 10) $display("FAIL neg_first got %0d want 10", vfirst); else passed++;
        total++; if (sum !== -20'sd30) $display("FAIL neg_sum got %0d want -30", sum); else passed++;
        total++; if (out !== -14'sd8) $display("FAIL neg_out got %0d want -8", out); else passed++;
        shift = 6'd63;
        run(10, 1'b0);
        total++; if (out !== -14'sd1) $display("FAIL neg_bigshift got %0d want -1", out); else passed++;
    endtask

    task automatic test_saturation();
        do_reset();
        en = 1'b1; log_n = 4'd0; shift = 6'd0; in_hi = 14'sd8191; in_lo = 14'sd8191;
        run(1, 1'b0);
        run(99, 1'b1);
        ph = 0;
        run(1, 1'b0);
        total++; if (vcount !== 1) $display("FAIL sat_valid got %0d want 1", vcount); else passed++;
        total++; if (sum !== 20'sd524287) $display("FAIL sat_sum got %0d want 524287", sum); else passed++;
        total++; if (ovf !== 1'b1) $display("FAIL sat_ovf got %b want 1", ovf); else passed++;
        total++; if (nsamp !== 32'd100) $display("FAIL sat_nsamp got %0d want 100", nsamp); else passed++;
        total++; if (out !== 14'sd8191) $display("FAIL sat_out got %0d want 8191", out); else passed++;
        run(10, 1'b0);
        total++; if (vfirst !== 110) $display("FAIL sat2_first got %0d want 110", vfirst); else passed++;
        total++; if (sum !== 20'sd81910) $display("FAIL sat2_sum got %0d want 81910", sum); else passed++;
        total++; if (ovf !== 1'b0) $display("FAIL sat2_ovf got %b want 0", ovf); else passed++;
        total++; if (out !== 14'sd8191) $display("FAIL sat2_out got %0d want 8191", out); else passed++;
    endtask

    task automatic test_demod();
        do_reset();
        en = 1'b1; log_n = 4'd0; shift = 6'd0; in_hi = 14'sd57; in_lo = -14'sd43;
        run(21, 1'b0);
        total++; if (vcount !== 2) $display("FAIL demod_count got %0d want 2", vcount); else passed++;
        total++; if (sum !== 20'sd70) $display("FAIL demod_sum got %0d want 70", sum); else passed++;
    endtask

    task automatic test_abort();
        do_reset();
        en = 1'b1; log_n = 4'd0; shift = 6'd0; in_hi = 14'sd100; in_lo = 14'sd100;
        run(11, 1'b0);
        total++; if (sum !== 20'sd1000) $display("FAIL abort_pre got %0d want 1000", sum); else passed++;
        in_hi = 14'sd200; in_lo = 14'sd200;
        run(3, 1'b0);
        en = 1'b0;
        run(3, 1'b0);
        en = 1'b1;
        run(13, 1'b0);
        total++; if (vcount !== 0) $display("FAIL abort_novalid got %0d want 0", vcount); else passed++;
        total++; if (sum !== 20'sd1000) $display("FAIL abort_hold_sum got %0d want 1000", sum); else passed++;
        total++; if (nsamp !== 32'd10) $display("FAIL abort_hold_n got %0d want 10", nsamp); else passed++;
        run(1, 1'b0);
        total++; if (vcount !== 1 || sum !== 20'sd2000) $display("FAIL abort_reopen got %0d/%0d want 1/2000", vcount, sum); else passed++;
        run(3, 1'b0);
        rst = 1'b0;
        ref_in = 1'b0;
        #1;
        total++; if (sum !== 20'sd0 || nsamp !== 32'd0) $display("FAIL rst_async got %0d/%0d want 0/0", sum, nsamp); else passed++;
        total++; if (out !== 14'sd0 || ovf !== 1'b0) $display("FAIL rst_async_out got %0d/%b want 0/0", out, ovf); else passed++;
        @(posedge clk);
        #1;
        rst = 1'b1;
        ph = 0;
        cyc = 0;
        prev_v = 1'b0;
        run(10, 1'b0);
        total++; if (vcount !== 0 || sum !== 20'sd0) $display("FAIL rst_discard got %0d/%0d want 0/0", vcount, sum); else passed++;
        run(1, 1'b0);
        total++; if (vcount !== 1 || sum !== 20'sd2000) $display("FAIL rst_first got %0d/%0d want 1/2000", vcount, sum); else passed++;
        total++; if (nsamp !== 32'd10) $display("FAIL rst_first_n got %0d want 10", nsamp); else passed++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_multi_period();
        test_negative_floor();
        test_saturation();
        test_demod();
        test_abort();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
